// File: rtl/serv_bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: state encoding, requester
// indices, the request bundle type and the error-read constant.
package serv_bus_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] GNT_E = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_GNT_I = GNT_I,
        ST_GNT_D = GNT_D,
        ST_GNT_E = GNT_E
    } state_t;

    // Read data returned to a requester whose transaction timed out.
    localparam logic [31:0] ERR_RDT = 32'd0;

    // Requester slots; bit positions in the one-hot grant vector.
    localparam int REQ_I   = 0;
    localparam int REQ_D   = 1;
    localparam int REQ_E   = 2;
    localparam int NUM_REQ = 3;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
    } wb_req_t;

    // Grant decision made in IDLE. After an external grant the CPU gets the
    // next slot if it is asking; otherwise ext > dbus > ibus.
    function automatic state_t pick_winner(input logic last_ext,
                                           input logic ibus_cyc,
                                           input logic dbus_cyc,
                                           input logic ext_cyc);
        state_t w;
        w = ST_IDLE;
        if (last_ext && (dbus_cyc || ibus_cyc))
            w = dbus_cyc ? ST_GNT_D : ST_GNT_I;
        else if (ext_cyc)
            w = ST_GNT_E;
        else if (dbus_cyc)
            w = ST_GNT_D;
        else if (ibus_cyc)
            w = ST_GNT_I;
        return w;
    endfunction

endpackage

// File: rtl/serv_bus_watchdog.sv
// Bus-timeout watchdog: counts granted cycles without ack and flags the
// last permitted cycle. TIMEOUT=0 disables it entirely.
module serv_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expire
);

    // Guard against a zero-width counter when the watchdog is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

    logic [CW-1:0] count_reg;

    // Clear on each new grant; count idle granted cycles, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (!i_rst_n)
            count_reg <= '0;
        else if (i_start)
            count_reg <= '0;
        else if (i_active && !i_ack && (count_reg != SAT))
            count_reg <= count_reg + 1'b1;
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign o_expire = 1'b0;
        end else begin : g_enabled
            assign o_expire = i_active & (count_reg == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master between the core's ibus, dbus and an external
// requester. Registered grant, combinational request/response muxing with
// zero added ack latency, and a watchdog that turns a hung slave into an
// error response.
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    input  logic [31:0] i_ext_adr,
    input  logic [31:0] i_ext_dat,
    input  logic [3:0]  i_ext_sel,
    input  logic        i_ext_we,
    input  logic        i_ext_cyc,
    output logic [31:0] o_ext_rdt,
    output logic        o_ext_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    state_t               state_reg;
    logic                 last_ext_reg;
    state_t               winner;
    wb_req_t              req [NUM_REQ];
    wb_req_t              sel_req;
    logic [NUM_REQ-1:0]   gnt;
    logic                 granted;
    logic                 expire;
    logic                 timeout_fire;
    logic                 done;
    logic                 start;
    logic [NUM_REQ-1:0]   rsp_ack;
    logic [31:0]          rsp_rdt [NUM_REQ];

    // Normalise the three requesters; ibus is a read-only full-word fetch.
    assign req[REQ_I] = '{adr: i_ibus_adr, dat: 32'd0, sel: 4'hF, we: 1'b0, cyc: i_ibus_cyc};
    assign req[REQ_D] = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we, cyc: i_dbus_cyc};
    assign req[REQ_E] = '{adr: i_ext_adr, dat: i_ext_dat, sel: i_ext_sel, we: i_ext_we, cyc: i_ext_cyc};

    assign gnt[REQ_I] = (state_reg == ST_GNT_I);
    assign gnt[REQ_D] = (state_reg == ST_GNT_D);
    assign gnt[REQ_E] = (state_reg == ST_GNT_E);
    assign granted    = |gnt;

    // Route the granted requester to the master port; all zero in IDLE.
    always_comb begin
        sel_req = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt[k])
                sel_req = req[k];
    end

    // Decide the next owner from the current requests and fairness bit.
    always_comb begin
        winner = pick_winner(last_ext_reg, i_ibus_cyc, i_dbus_cyc, i_ext_cyc);
    end

    assign start = (state_reg == ST_IDLE) && (winner != ST_IDLE);

    serv_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_start  (start),
        .i_active (granted),
        .i_ack    (i_wb_ack),
        .o_expire (expire)
    );

    // A real ack beats the watchdog; an aborted requester gets no error ack.
    assign timeout_fire = granted & sel_req.cyc & expire & ~i_wb_ack;
    assign done         = i_wb_ack | timeout_fire | ~sel_req.cyc;

    assign o_wb_adr  = sel_req.adr;
    assign o_wb_dat  = sel_req.dat;
    assign o_wb_sel  = sel_req.sel;
    assign o_wb_we   = sel_req.we;
    assign o_wb_cyc  = sel_req.cyc & ~timeout_fire;
    assign o_timeout = timeout_fire;

    // Per-requester response: only the owner sees ack or read data.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_ack[gi] = gnt[gi] & (i_wb_ack | timeout_fire);
            assign rsp_rdt[gi] = (gnt[gi] && !timeout_fire) ? i_wb_rdt : ERR_RDT;
        end
    endgenerate

    assign o_ibus_ack = rsp_ack[REQ_I];
    assign o_ibus_rdt = rsp_rdt[REQ_I];
    assign o_dbus_ack = rsp_ack[REQ_D];
    assign o_dbus_rdt = rsp_rdt[REQ_D];
    assign o_ext_ack  = rsp_ack[REQ_E];
    assign o_ext_rdt  = rsp_rdt[REQ_E];

    // Grant FSM: IDLE picks a winner, a grant ends on ack, timeout or abort.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            last_ext_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (winner != ST_IDLE) begin
                        state_reg    <= winner;
                        last_ext_reg <= (winner == ST_GNT_E);
                    end
                end
                default: begin
                    if (done)
                        state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Bench for serv_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an owner/wait-count reference model.
module tb_serv_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr = '0, dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0, dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] ext_adr = '0, ext_dat = '0;
    logic [3:0]  ext_sel = '0;
    logic        ext_we = 1'b0, ext_cyc = 1'b0;
    logic [31:0] ext_rdt;
    logic        ext_ack;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack = 1'b0;
    logic        timeout;

    always #5 clk = ~clk;

    serv_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .i_ext_adr  (ext_adr),
        .i_ext_dat  (ext_dat),
        .i_ext_sel  (ext_sel),
        .i_ext_we   (ext_we),
        .i_ext_cyc  (ext_cyc),
        .o_ext_rdt  (ext_rdt),
        .o_ext_ack  (ext_ack),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat),
        .o_wb_sel   (wb_sel),
        .o_wb_we    (wb_we),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack),
        .o_timeout  (timeout)
    );

    int   checks = 0;
    int   passed = 0;
    // Reference model: who owns the bus (-1 none, 0 ibus, 1 dbus, 2 ext),
    // how many granted cycles have passed without ack, and the fairness bit.
    int   m_own = -1;
    int   m_wait = 0;
    bit   m_last_ext = 1'b0;
    logic e_ack [3];
    string names [3] = '{"ibus", "dbus", "ext"};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check outputs mid-cycle against the model, advance the
    // model, then after the edge release the ack pulse and any acked requester.
    task automatic cycle();
        logic        cyc_v [3];
        logic [31:0] adr_v [3];
        logic [31:0] dat_v [3];
        logic [3:0]  sel_v [3];
        logic        we_v  [3];
        logic        rc, tmo;
        logic [100:0] e_wb;
        logic [32:0] e_rsp [3];
        int          w;
        @(negedge clk);
        cyc_v = '{ibus_cyc, dbus_cyc, ext_cyc};
        adr_v = '{ibus_adr, dbus_adr, ext_adr};
        dat_v = '{32'd0, dbus_dat, ext_dat};
        sel_v = '{4'hF, dbus_sel, ext_sel};
        we_v  = '{1'b0, dbus_we, ext_we};
        rc  = (m_own >= 0) ? cyc_v[m_own] : 1'b0;
        tmo = (TO != 0) && (m_own >= 0) && rc && !wb_ack && (m_wait == TO - 1);
        e_wb = '0;
        if (m_own >= 0)
            e_wb = {adr_v[m_own], dat_v[m_own], sel_v[m_own], we_v[m_own], rc && !tmo};
        for (int i = 0; i < 3; i++) begin
            e_ack[i] = (m_own == i) && (wb_ack || tmo);
            e_rsp[i] = {((m_own == i) && !tmo) ? wb_rdt : 32'd0, e_ack[i]};
        end
        chk("wb_req", {wb_adr, wb_dat, wb_sel, wb_we, wb_cyc}, e_wb);
        chk("ibus_rsp", {ibus_rdt, ibus_ack}, e_rsp[0]);
        chk("dbus_rsp", {dbus_rdt, dbus_ack}, e_rsp[1]);
        chk("ext_rsp", {ext_rdt, ext_ack}, e_rsp[2]);
        chk("timeout", timeout, tmo);
        for (int i = 0; i < 3; i++)
            if (e_ack[i])
                $display("txn %s adr=%h rdt=%h timeout=%0d t=%0t",
                         names[i], adr_v[i], e_rsp[i][32:1], tmo, $time);
        // model update for the coming edge
        if (!rst_n) begin
            m_own = -1;
            m_last_ext = 1'b0;
        end else if (m_own < 0) begin
            w = -1;
            if (m_last_ext && (cyc_v[1] || cyc_v[0])) w = cyc_v[1] ? 1 : 0;
            else if (cyc_v[2]) w = 2;
            else if (cyc_v[1]) w = 1;
            else if (cyc_v[0]) w = 0;
            if (w >= 0) begin
                m_own = w;
                m_wait = 0;
                m_last_ext = (w == 2);
            end
        end else if (wb_ack || tmo || !rc) begin
            m_own = -1;
        end else begin
            m_wait++;
        end
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        if (e_ack[0]) ibus_cyc = 1'b0;
        if (e_ack[1]) dbus_cyc = 1'b0;
        if (e_ack[2]) ext_cyc = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cycle();                 // still in reset: everything must be 0
        rst_n = 1'b1;
        cycle();

        // ibus read alone, slave acks two cycles after o_wb_cyc rises
        ibus_adr = 32'h100; ibus_cyc = 1'b1;
        cycle(); cycle(); cycle();
        wb_rdt = 32'hDEADBEEF; wb_ack = 1'b1;
        cycle(); cycle();

        // ext and dbus together: ext first, dbus at ack+2
        ext_adr = 32'h2000; ext_dat = 32'hA5A5A5A5; ext_sel = 4'hF; ext_we = 1'b1; ext_cyc = 1'b1;
        dbus_adr = 32'h3000; dbus_sel = 4'hF; dbus_we = 1'b0; dbus_cyc = 1'b1;
        cycle(); cycle();
        wb_ack = 1'b1; cycle();
        cycle(); cycle();
        wb_rdt = 32'h12345678; wb_ack = 1'b1; cycle();
        // ext again, ibus queues behind it, then ext re-requests: ibus wins
        ext_adr = 32'h2004; ext_cyc = 1'b1; cycle();
        ibus_adr = 32'h104; ibus_cyc = 1'b1; cycle();
        wb_ack = 1'b1; cycle();
        ext_adr = 32'h2008; ext_cyc = 1'b1; cycle();
        wb_rdt = 32'hCAFEF00D; wb_ack = 1'b1; cycle();
        cycle();
        wb_ack = 1'b1; cycle(); cycle();

        // watchdog expiry on a dbus read that is never acked
        dbus_adr = 32'h4000; dbus_we = 1'b0; dbus_cyc = 1'b1;
        cycle(); repeat (4) cycle(); cycle();

        // ack on the final watchdog cycle wins over the timeout
        dbus_adr = 32'h4004; dbus_cyc = 1'b1;
        cycle(); repeat (3) cycle();
        wb_rdt = 32'h0BADC0DE; wb_ack = 1'b1; cycle(); cycle();

        // dbus aborts mid-grant, pending ibus follows two cycles later
        dbus_adr = 32'h5000; dbus_cyc = 1'b1; ibus_adr = 32'h108; ibus_cyc = 1'b1;
        cycle(); cycle();
        dbus_cyc = 1'b0; cycle();
        cycle(); cycle();
        wb_rdt = 32'h00C0FFEE; wb_ack = 1'b1; cycle(); cycle();

        // reset during an ext grant, then a late ack must go nowhere
        ext_adr = 32'h6000; ext_cyc = 1'b1;
        cycle(); cycle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; ext_cyc = 1'b0; wb_rdt = 32'h11111111; wb_ack = 1'b1; cycle();
        cycle();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom % 150) != 0;
            if (!ibus_cyc && ($urandom % 4 == 0)) begin
                ibus_adr = $urandom; ibus_cyc = 1'b1;
            end else if (ibus_cyc && ($urandom % 40 == 0)) ibus_cyc = 1'b0;
            if (!dbus_cyc && ($urandom % 4 == 0)) begin
                dbus_adr = $urandom; dbus_dat = $urandom; dbus_sel = 4'($urandom);
                dbus_we = 1'($urandom); dbus_cyc = 1'b1;
            end else if (dbus_cyc && ($urandom % 40 == 0)) dbus_cyc = 1'b0;
            if (!ext_cyc && ($urandom % 5 == 0)) begin
                ext_adr = $urandom; ext_dat = $urandom; ext_sel = 4'($urandom);
                ext_we = 1'($urandom); ext_cyc = 1'b1;
            end else if (ext_cyc && ($urandom % 40 == 0)) ext_cyc = 1'b0;
            wb_rdt = $urandom;
            wb_ack = ($urandom % 3) == 0;
            cycle();
        end

        rst_n = 1'b1; ibus_cyc = 1'b0; dbus_cyc = 1'b0; ext_cyc = 1'b0;
        cycle(); cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serv_bus_arbiter.md
# serv_bus_arbiter

Shares one Wishbone master port between the core's instruction bus, its data bus, and an external requester (boot loader / debug DMA). It sits between the core top level and the single-ported memory or interconnect. It owns grant sequencing, fair priority, response routing and a bus-timeout watchdog.

## Interface
- `TIMEOUT`, default 255: cycles a granted transaction may wait for ack before a forced error response; 0 disables the watchdog.
- `clk` in 1: clock, all logic on rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_ibus_adr` in 32, `i_ibus_cyc` in 1: instruction-fetch request (read only).
- `o_ibus_rdt` out 32, `o_ibus_ack` out 1: instruction response.
- `i_dbus_adr` in 32, `i_dbus_dat` in 32, `i_dbus_sel` in 4, `i_dbus_we` in 1, `i_dbus_cyc` in 1: data request.
- `o_dbus_rdt` out 32, `o_dbus_ack` out 1: data response.
- `i_ext_adr` in 32, `i_ext_dat` in 32, `i_ext_sel` in 4, `i_ext_we` in 1, `i_ext_cyc` in 1: external request.
- `o_ext_rdt` out 32, `o_ext_ack` out 1: external response.
- `o_wb_adr` out 32, `o_wb_dat` out 32, `o_wb_sel` out 4, `o_wb_we` out 1, `o_wb_cyc` out 1: shared master request.
- `i_wb_rdt` in 32, `i_wb_ack` in 1: shared master response.
- `o_timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, GNT_I, GNT_D, GNT_E. Grant is registered.
- IDLE: when any `cyc` is high, select the winner and go to the matching GNT state at the next edge.
- Priority: if `last_ext`=1 and `i_dbus_cyc` or `i_ibus_cyc` is high, the CPU wins. Otherwise the order is ext > dbus > ibus. `last_ext` is set on every GNT_E entry and cleared on every GNT_I/GNT_D entry.
- GNT_x: `o_wb_adr`/`dat`/`sel`/`we` mux combinationally from requester x. Ibus forces `we`=0, `sel`=4'hF, `dat`=0. `o_wb_cyc` = requester x `cyc`.
- In IDLE, master outputs are all 0.
- Response: `o_x_ack` = `i_wb_ack` & GNT_x; `o_x_rdt` = `i_wb_rdt` when granted, else 0. Non-granted requesters never see ack.
- Exit GNT_x to IDLE on ack, on timeout, or if requester x drops `cyc` (abort, no ack).
- Watchdog: counter clears on GNT entry and increments each granted cycle without ack. On the cycle it equals TIMEOUT-1:
  - assert `o_x_ack` with `o_x_rdt`=0;
  - pulse `o_timeout`;
  - force `o_wb_cyc`=0 that cycle;
  - return to IDLE.
- Ack and timeout in the same cycle: the real ack wins, no `o_timeout`.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values: state IDLE, `last_ext`=0, counter 0. All acks, `o_wb_cyc`, `o_timeout` and every master output are 0.
- Request latency: `cyc` sampled high at edge N, so `o_wb_cyc`=1 from cycle N+1.
- Ack latency: `o_x_ack` is asserted in the same cycle as `i_wb_ack` (zero added latency).
- Back-to-back: ack in cycle M gives IDLE in M+1 and the earliest next `o_wb_cyc` in M+2. There is exactly one dead cycle between transactions.
- Requests arriving during a grant wait. Requesters hold `cyc` and request signals stable until ack (Wishbone classic).
- Reset mid-transaction: at the edge where `i_rst_n`=0 is sampled, go to IDLE. `o_wb_cyc` is 0 the following cycle and no ack is generated.
- Ack arriving in IDLE is ignored.

## Structure
- Shared header holds:
  - state encoding localparams (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, GNT_E=2'd3);
  - the 32'd0 error-read constant.
- One sub-module, `serv_bus_watchdog`:
  - inputs: `clk`, `i_rst_n`, `i_start`, `i_active`, `i_ack`;
  - output: `o_expire`;
  - parameter `TIMEOUT`.
- Arbiter FSM, priority logic and muxes live in `serv_bus_arbiter`.

## Test plan
- Ibus read alone: `i_ibus_cyc`=1, adr 0x100, memory acks 2 cycles after `o_wb_cyc`. Expect `o_wb_cyc` one cycle after request, `o_wb_we`=0, `sel`=F, `o_ibus_ack` coincident with `i_wb_ack`, rdt passed through.
- Simultaneous ext and dbus, `last_ext`=0: ext (adr 0x2000, we=1, dat 0xA5A5A5A5) granted first. Dbus is granted at ack+2. Then ext re-requests while ibus is requesting: ibus wins.
- Watchdog: TIMEOUT=4, dbus read, no ack. Expect `o_dbus_ack`=1 with rdt=0 and `o_timeout`=1 on the 4th granted cycle, IDLE afterwards.
- Ack on the final watchdog cycle (TIMEOUT=4, ack on cycle 4): normal ack, `o_timeout`=0.
- Abort: dbus drops `cyc` mid-grant. `o_wb_cyc` falls in the same cycle, no ack, and pending ibus is granted 2 cycles later.
- Reset mid-grant: assert `i_rst_n`=0 during GNT_E. Next cycle all outputs are 0 and a late `i_wb_ack` produces no requester ack.
